// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared constants for the fetch stage and the D-stage decoder: reset and
// exception vectors, the legal instruction-memory window, the AdEL exception
// code, and the opcode/funct encodings of the control-transfer instructions.
// It also holds the fetch FSM state type.

package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_LAST_DEF  = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_READY = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_jmp_detect.sv
// fetch_unit_jmp_detect
// Combinational flag for instructions that own a branch delay slot
// (beq, bne, j, jal, jr, jalr).
// Ports:
//   instr   in  32  instruction word
//   is_jmp  out 1   instruction is a branch or jump

module fetch_unit_jmp_detect
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_jmp
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_mid;

    assign op         = instr[31:26];
    assign funct      = instr[5:0];
    assign unused_mid = ^instr[25:6];

    always_comb begin
        is_jmp = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_J, OP_JAL: is_jmp = 1'b1;
            OP_SPECIAL: is_jmp = (funct == FUNCT_JR) || (funct == FUNCT_JALR);
            default: is_jmp = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// F-stage producer for the F/D pipeline register. Owns the PC, fetches over a
// req/ack handshake, and presents pc/instr/delay-slot/exception to D.
// Ports:
//   clk, reset (async, active low)
//   stall               D register not accepting
//   Req, eret, epc      exception entry / exception return redirects
//   branch_taken/target taken control transfer resolved in D
//   i_req, i_addr       instruction-memory request and word address
//   i_rdata, i_ack      returned word and one-cycle completion pulse
//   F_valid, F_pc, F_instr, F_DelaySlot, F_EXCcode   presented instruction
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FETCH | requesting word at pc (or flagging AdEL without a request)
// ST_READY | instruction presented to D, waiting for !stall
// ST_FLUSH | redirected with a request in flight; drain it, drop the data

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter logic [31:0] IM_LAST  = IM_LAST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    input  logic        i_ack,
    output logic        F_valid,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_DelaySlot,
    output logic [4:0]  F_EXCcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [4:0]   exc_q, exc_d;
    logic         ds_q, ds_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic [31:0]  flush_addr_q, flush_addr_d;

    logic         adel;
    logic         instr_is_jmp;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  next_pc;

    fetch_unit_jmp_detect u_jmp_detect (
        .instr  (instr_q),
        .is_jmp (instr_is_jmp)
    );

    // pc+4 is allowed to wrap; the range check turns a wrapped pc into AdEL.
    assign adel        = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
    assign redirect    = Req | eret;
    assign redirect_pc = Req ? EXC_PC : epc;
    assign next_pc     = pend_valid_q ? pend_target_q : pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            exc_q         <= EXC_NONE;
            ds_q          <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            flush_addr_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            exc_q         <= exc_d;
            ds_q          <= ds_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            flush_addr_q  <= flush_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        exc_d         = exc_q;
        ds_d          = ds_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        flush_addr_d  = flush_addr_q;

        if (branch_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
        end

        case (state_q)
            ST_FETCH: begin
                if (adel) begin
                    instr_d = 32'h0;
                    exc_d   = EXC_ADEL;
                    state_d = ST_READY;
                end else if (i_ack) begin
                    instr_d = i_rdata;
                    exc_d   = EXC_NONE;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (!stall) begin
                    // A pending target is consumed by exactly one handoff: the delay slot.
                    pc_d         = next_pc;
                    ds_d         = instr_is_jmp;
                    pend_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (i_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Redirects win over the handoff and over stall.
        if (redirect) begin
            pc_d         = redirect_pc;
            ds_d         = 1'b0;
            pend_valid_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (adel || i_ack) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d      = ST_FLUSH;
                        flush_addr_d = pc_q;
                    end
                end
                ST_FLUSH: state_d = ST_FLUSH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        i_req       = reset && (((state_q == ST_FETCH) && !adel) || (state_q == ST_FLUSH));
        i_addr      = (state_q == ST_FLUSH) ? flush_addr_q : pc_q;
        F_valid     = (state_q == ST_READY);
        F_pc        = pc_q;
        F_instr     = F_valid ? instr_q : 32'h0;
        F_DelaySlot = F_valid & ds_q;
        F_EXCcode   = F_valid ? exc_q : EXC_NONE;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, Req, eret, branch_taken, i_ack;
    logic [31:0] epc, branch_target, i_rdata;
    logic        i_req, F_valid, F_DelaySlot;
    logic [31:0] i_addr, F_pc, F_instr;
    logic [4:0]  F_EXCcode;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .Req(Req), .eret(eret), .epc(epc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .F_valid(F_valid), .F_pc(F_pc), .F_instr(F_instr),
        .F_DelaySlot(F_DelaySlot), .F_EXCcode(F_EXCcode)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ds;
        logic [4:0]  exc;
    } entry_t;

    entry_t      exp_q[$];
    int          checks   = 0;
    int          passed   = 0;
    int          handoffs = 0;
    bit          run      = 0;
    int unsigned max_d    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6FFC);
    endfunction

    // Instruction memory image: a hash of the address, with a good share of
    // branch/jump encodings so delay slots occur often.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h3000) return 32'h3C01_0001;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 13);
        case (h[2:0])
            3'd0:    return {6'h04, h[28:3]};
            3'd1:    return {6'h00, h[25:6], 6'h08};
            3'd2:    return {6'h03, h[28:3]};
            3'd3:    return {6'h00, h[25:6], 6'h09};
            default: return h;
        endcase
    endfunction

    function automatic bit m_is_jmp(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        return (op inside {6'h04, 6'h05, 6'h02, 6'h03}) || (op == 6'h00 && (fn inside {6'h08, 6'h09}));
    endfunction

    function automatic entry_t mk(input logic [31:0] a, input logic ds);
        entry_t e;
        e.pc = a;
        e.ds = ds;
        if (legal(a)) begin
            e.instr = mem_word(a);
            e.exc   = 5'd0;
        end else begin
            e.instr = 32'h0;
            e.exc   = 5'd4;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 15);
        case (k)
            0:       return 32'h3000 + ($urandom_range(0, 4095) << 2) + 32'd2;
            1:       return 32'h7000;
            2:       return 32'h6FFC;
            3:       return 32'hFFFF_FFFC;
            4:       return 32'h2FFC;
            default: return 32'h3000 + ($urandom_range(0, 4095) << 2);
        endcase
    endfunction

    // Instruction memory: random 0..max_d wait per request, zero-wait allowed.
    initial begin : mem_model
        bit          busy;
        int unsigned cnt;
        logic [31:0] addr0;
        busy = 0; cnt = 0; addr0 = 0;
        i_ack = 1'b0;
        i_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            i_ack   = 1'b0;
            i_rdata = $urandom;
            if (!i_req) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy  = 1;
                    cnt   = $urandom_range(0, max_d);
                    addr0 = i_addr;
                    check("fetch_addr_legal", 32'(legal(i_addr)), 32'd1);
                end else begin
                    check("i_addr_stable", i_addr, addr0);
                end
                if (cnt == 0) begin
                    i_ack   = 1'b1;
                    i_rdata = mem_word(i_addr);
                    busy    = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every accepted instruction is compared against the scoreboard.
    initial begin : monitor
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (run && F_valid && !stall && !Req && !eret) begin
                handoffs++;
                check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("F_pc", F_pc, e.pc);
                    check("F_instr", F_instr, e.instr);
                    check("F_DelaySlot", 32'(F_DelaySlot), 32'(e.ds));
                    check("F_EXCcode", 32'(F_EXCcode), 32'(e.exc));
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] m_pc, m_tgt, m_instr, pulse_tgt;
        bit          m_pend, pulse_next, fv, nds;
        int unsigned r;
        entry_t      e;

        reset = 1'b0; stall = 1'b1; Req = 1'b0; eret = 1'b0;
        epc = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_i_req", 32'(i_req), 32'd0);
        check("rst_F_valid", 32'(F_valid), 32'd0);
        check("rst_F_instr", F_instr, 32'h0);
        check("rst_F_pc", F_pc, 32'h3000);
        check("rst_F_DelaySlot", 32'(F_DelaySlot), 32'd0);
        check("rst_F_EXCcode", 32'(F_EXCcode), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #2;
        check("c1_i_req", 32'(i_req), 32'd1);
        check("c1_i_addr", i_addr, 32'h3000);
        @(negedge clk);
        #2;
        check("c2_F_valid", 32'(F_valid), 32'd1);
        check("c2_F_pc", F_pc, 32'h3000);
        check("c2_F_instr", F_instr, 32'h3C01_0001);
        check("c2_i_req", 32'(i_req), 32'd0);

        m_pc = 32'h3000; m_pend = 0; m_tgt = 0; pulse_next = 0; pulse_tgt = 0;
        e = mk(m_pc, 1'b0);
        m_instr = e.instr;
        exp_q.push_back(e);
        max_d = 3;
        run = 1;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            fv    = F_valid;
            stall = ($urandom_range(0, 2) == 0);
            r     = $urandom_range(0, 39);
            Req   = (r < 2);
            eret  = (r == 1) || (r == 2);
            epc   = rand_addr();
            branch_taken  = pulse_next;
            branch_target = pulse_tgt;
            if (pulse_next) begin
                m_pend = 1;
                m_tgt  = pulse_tgt;
            end
            pulse_next = 0;
            if (Req || eret) begin
                m_pc   = Req ? 32'h4180 : epc;
                m_pend = 0;
                exp_q.delete();
                e = mk(m_pc, 1'b0);
                m_instr = e.instr;
                exp_q.push_back(e);
            end else if (fv && !stall) begin
                nds    = m_is_jmp(m_instr);
                m_pc   = m_pend ? m_tgt : m_pc + 32'd4;
                m_pend = 0;
                e = mk(m_pc, nds);
                m_instr = e.instr;
                exp_q.push_back(e);
                if (nds && $urandom_range(0, 3) != 0) begin
                    pulse_next = 1;
                    pulse_tgt  = rand_addr();
                end
            end
        end

        @(negedge clk);
        stall = 1'b1; Req = 1'b0; eret = 1'b0; branch_taken = 1'b0;
        repeat (4) @(negedge clk);
        check("handoff_progress", 32'(handoffs > 300), 32'd1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
